mult_dot_accum: RTL and testbench
=================================

Name: mult_dot_accum

Overview:
- Drives the 4x4 two's-complement add-shift multiplier from an operand stream and consumes its 7-bit Product/Done.
- Accepts operand pairs over a valid/ready handshake and launches one multiplication per pair.
- Sign-extends each product and accumulates N_TERMS products into a dot-product sum, which it presents with a one-cycle valid.
- Sits between the operand source and the result consumer; the multiplier is instantiated alongside it by the parent.

Parameters:
N_TERMS, 4, products per dot-product vector (>=1)
ACC_W, 12, accumulator/Sum width in bits, signed (>=8)
TIMEOUT, 8, max WAIT cycles without Done before abort
DRAIN_CYC, 6, cycles InReady is held low after reset/abort so an in-flight multiplication completes

Ports:
CLK  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
InValid  in  1  operand pair valid
InReady  out  1  block can accept a pair
InA  in  4  multiplier operand, signed
InB  in  4  multiplicand operand, signed
St  out  1  start pulse to multiplier
Mplier  out  4  to multiplier; holds the InA register
Mcand  out  4  to multiplier; holds the InB register
Product  in  7  multiplier result, signed; valid while Done=1
Done  in  1  multiplier done, one-cycle pulse
Sum  out  ACC_W  final dot-product, signed
SumValid  out  1  one-cycle pulse; Sum and Overflow are valid
Overflow  out  1  signed overflow occurred in the vector; valid with SumValid
Err  out  1  sticky timeout flag; cleared only by Reset

Behaviour:
- Reset (async): state=DRAIN, drain count=0, St=0, Mplier=0, Mcand=0, InReady=0, accumulator=0, term count=0, Sum=0, SumValid=0, Overflow=0, Err=0.
- States: DRAIN, IDLE, LAUNCH, WAIT. InReady=1 only in IDLE. All outputs are registered or decoded from state.
- DRAIN: count DRAIN_CYC cycles, then go to IDLE. Done is ignored.
- IDLE: on InValid&&InReady, latch InA->Mplier and InB->Mcand, then go to LAUNCH. Done in IDLE is ignored (spurious).
- LAUNCH: St=1 for exactly this cycle, then go to WAIT and clear the wait counter.
- Mplier and Mcand are held stable from acceptance until the cycle after Done, because the multiplier reads Mcand every add cycle.
- WAIT: Done=1 causes, in the same cycle, sext(Product) to be added into the accumulator and term count+1, then IDLE.
  - Done arrives on the 5th WAIT cycle.
  - Per-term interval is 7 cycles with InValid held high: accept, LAUNCH, 4 busy, Done.
- Final term: when Done arrives with term count==N_TERMS-1, the next cycle shows:
  - Sum = accumulator + sext(Product)
  - SumValid=1 for 1 cycle, Overflow = sticky overflow OR this step's overflow
  - accumulator, term count and sticky overflow cleared.
  Sum holds its value until the next SumValid. Acceptance of the next pair in the SumValid cycle is allowed.
- Arithmetic:
  - Product is 7-bit two's complement, sign-extended to ACC_W; the sum wraps modulo 2^ACC_W.
  - Overflow per step = operands' signs equal and result sign differs.
  - The pair (-8,-8) is unsupported by the multiplier (+64 is not representable); it is not checked and is accumulated as -64.
- Timeout: if the wait counter reaches TIMEOUT in WAIT without Done:
  - Err=1 (sticky); accumulator, term count and sticky overflow cleared
  - no SumValid; go to DRAIN.
- Done and timeout on the same cycle: Done wins.
- Reset mid-vector: everything returns to reset values. DRAIN guarantees the multiplier (which has no reset) is back in its idle state before the next St.

Decomposition:
- Shared package: state encoding (DRAIN/IDLE/LAUNCH/WAIT), MULT_LATENCY=5, default ACC_W/TIMEOUT/DRAIN_CYC constants.
- One natural sub-module: mult_acc_add. It is combinational: sign-extend the 7-bit Product, ACC_W add, signed-overflow detect.
- FSM and counters stay in the top.

Test Plan:
- Reset release with InValid=1 -> InReady=0 for 6 cycles, then 1; St never asserted during DRAIN.
- Pairs (3,2),(-1,5),(7,7),(-8,1) with a behavioural multiplier -> products 6,-5,49,-8. Required: SumValid one pulse, Sum=12'h02A, Overflow=0, St pulses spaced 7 cycles apart.
- Two back-to-back vectors: (1,1)x4 then (-1,1)x4 -> Sum=4, then Sum=-4 (12'hFFC); the accumulator clears between vectors.
- ACC_W=8, four pairs (7,7) -> Sum=8'hC4, Overflow=1.
- Multiplier Done suppressed -> Err=1 after 8 WAIT cycles, InReady=0 for 6 cycles, no SumValid. The next vector (2,3)x4 gives Sum=24 and Err stays 1.
- Spurious Done in IDLE, then Reset asserted during WAIT of term 2. Required: Done ignored; all outputs 0 during Reset, then DRAIN; the next vector sums from 0.

Source files
------------

// File: rtl/mult_dot_accum_pkg.sv
// Shared constants for the dot-product accumulator that drives
// the 4x4 add-shift multiplier: FSM encoding, latency, defaults.
package mult_dot_accum_pkg;

  localparam logic [1:0] S_DRAIN  = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_LAUNCH = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  localparam int MULT_LATENCY = 5;
  localparam int PROD_W       = 7;
  localparam int OPND_W       = 4;

  localparam int DEF_N_TERMS   = 4;
  localparam int DEF_ACC_W     = 12;
  localparam int DEF_TIMEOUT   = 8;
  localparam int DEF_DRAIN_CYC = 6;

  // Width of a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_acc_add.sv
// Sign-extends the 7-bit product, adds it to the accumulator and
// flags signed overflow. Ports: acc, product in; sum, ovf out.
module mult_acc_add
  import mult_dot_accum_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W-1:0] ext;

  assign ext = {{(ACC_W-PROD_W){product[PROD_W-1]}},
                product};

  assign sum = acc + ext;

  // Operands agree in sign but the result does not.
  assign ovf = (acc[ACC_W-1] == ext[ACC_W-1]) &&
               (sum[ACC_W-1] != acc[ACC_W-1]);

endmodule

// File: rtl/mult_dot_accum.sv
// Feeds operand pairs to the add-shift multiplier and accumulates
// N_TERMS products into a signed dot-product.
// Ports: CLK, Reset (async high); InValid/InReady/InA/InB operand
// handshake; St/Mplier/Mcand to multiplier; Product/Done from it;
// Sum/SumValid/Overflow result; Err sticky timeout flag.
module mult_dot_accum
  import mult_dot_accum_pkg::*;
#(
  parameter int N_TERMS   = DEF_N_TERMS,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [OPND_W-1:0] InA,
  input  logic [OPND_W-1:0] InB,
  output logic              St,
  output logic [OPND_W-1:0] Mplier,
  output logic [OPND_W-1:0] Mcand,
  input  logic [PROD_W-1:0] Product,
  input  logic              Done,
  output logic [ACC_W-1:0]  Sum,
  output logic              SumValid,
  output logic              Overflow,
  output logic              Err
);

  // A healthy multiplier must never be able to trip the timeout.
  localparam int WAIT_LIM =
    (TIMEOUT > MULT_LATENCY) ? TIMEOUT : MULT_LATENCY + 1;

  localparam int DC_W = cnt_w(DRAIN_CYC);
  localparam int WC_W = cnt_w(WAIT_LIM);
  localparam int TC_W = cnt_w(N_TERMS);

  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_CYC - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_LIM - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(N_TERMS - 1);

  logic [1:0]       state;
  logic [DC_W-1:0]  dcnt;
  logic [WC_W-1:0]  wcnt;
  logic [TC_W-1:0]  tcnt;
  logic [ACC_W-1:0] acc;
  logic             ovf_sticky;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             last_term;
  logic             timed_out;

  assign InReady   = (state == S_IDLE);
  assign St        = (state == S_LAUNCH);
  assign last_term = (tcnt == TC_LAST);
  assign timed_out = !Done && (wcnt == WC_LAST);

  mult_acc_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .acc    (acc),
    .product(Product),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  // Control FSM with drain and wait counters.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_DRAIN;
      dcnt  <= '0;
      wcnt  <= '0;
    end else begin
      unique case (state)
        S_DRAIN: begin
          if (dcnt == DC_LAST) begin
            dcnt  <= '0;
            state <= S_IDLE;
          end else begin
            dcnt <= dcnt + DC_W'(1);
          end
        end
        S_IDLE: begin
          if (InValid) state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (Done) begin
            state <= S_IDLE;
          end else if (timed_out) begin
            dcnt  <= '0;
            state <= S_DRAIN;
          end else begin
            wcnt <= wcnt + WC_W'(1);
          end
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

  // Operand registers: only loaded on acceptance, so they stay
  // stable through the whole multiplication.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Mplier <= '0;
      Mcand  <= '0;
    end else if (InReady && InValid) begin
      Mplier <= InA;
      Mcand  <= InB;
    end
  end

  // Accumulator, term counter and result registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      acc        <= '0;
      tcnt       <= '0;
      ovf_sticky <= 1'b0;
      Sum        <= '0;
      SumValid   <= 1'b0;
      Overflow   <= 1'b0;
      Err        <= 1'b0;
    end else begin
      SumValid <= 1'b0;
      if (state == S_WAIT) begin
        if (Done && last_term) begin
          Sum        <= add_sum;
          SumValid   <= 1'b1;
          Overflow   <= ovf_sticky | add_ovf;
          acc        <= '0;
          tcnt       <= '0;
          ovf_sticky <= 1'b0;
        end else if (Done) begin
          acc        <= add_sum;
          tcnt       <= tcnt + TC_W'(1);
          ovf_sticky <= ovf_sticky | add_ovf;
        end else if (timed_out) begin
          Err        <= 1'b1;
          acc        <= '0;
          tcnt       <= '0;
          ovf_sticky <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_dot_accum.sv
// Bench for mult_dot_accum: behavioural multiplier plus an
// arithmetic dot-product model; 12-bit and 8-bit instances share stimulus.
module tb_mult_dot_accum;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       InValid = 1'b0;
  logic [3:0] InA = '0;
  logic [3:0] InB = '0;
  logic [6:0] Product = '0;
  logic       Done = 1'b0;

  logic        rdy0, st0, sv0, ov0, err0;
  logic [3:0]  mpl0, mcd0;
  logic [11:0] sum0;
  logic        rdy8, st8, sv8, ov8, err8;
  logic [3:0]  mpl8, mcd8;
  logic [7:0]  sum8;

  always #5 CLK = ~CLK;

  mult_dot_accum #(.ACC_W(12)) dut0 (
    .CLK(CLK), .Reset(Reset),
    .InValid(InValid), .InReady(rdy0),
    .InA(InA), .InB(InB),
    .St(st0), .Mplier(mpl0), .Mcand(mcd0),
    .Product(Product), .Done(Done),
    .Sum(sum0), .SumValid(sv0),
    .Overflow(ov0), .Err(err0)
  );

  mult_dot_accum #(.ACC_W(8)) dut8 (
    .CLK(CLK), .Reset(Reset),
    .InValid(InValid), .InReady(rdy8),
    .InA(InA), .InB(InB),
    .St(st8), .Mplier(mpl8), .Mcand(mcd8),
    .Product(Product), .Done(Done),
    .Sum(sum8), .SumValid(sv8),
    .Overflow(ov8), .Err(err8)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mcnt = 0;
  int nsv0 = 0;
  int nsv8 = 0;
  int nst0 = 0;
  int nst8 = 0;
  int last_st = 0;
  int terms = 0;
  int r0 = 0;
  int r8 = 0;
  bit ovs0, ovs8;
  bit suppress = 1'b0;
  bit spurious = 1'b0;
  logic [6:0] mprod;
  logic [3:0] lastA, lastB;
  int st_q[$];
  logic [11:0] es0[$];
  bit eo0[$];
  logic [7:0] es8[$];
  bit eo8[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int v, input int w);
    int half = 1 << (w - 1);
    if (v >= half) return v - (1 << w);
    if (v < -half) return v + (1 << w);
    return v;
  endfunction

  function automatic bit out_of(input int v, input int w);
    int half = 1 << (w - 1);
    return (v >= half) || (v < -half);
  endfunction

  task automatic model_accept(input int a, input int b);
    int p = a * b;
    if (p == 64) p = -64;
    terms++;
    ovs0 |= out_of(r0 + p, 12);
    r0 = wrap(r0 + p, 12);
    ovs8 |= out_of(r8 + p, 8);
    r8 = wrap(r8 + p, 8);
    if (terms == 4) begin
      es0.push_back(12'(r0));
      eo0.push_back(ovs0);
      es8.push_back(8'(r8));
      eo8.push_back(ovs8);
      terms = 0; r0 = 0; r8 = 0;
      ovs0 = 0; ovs8 = 0;
    end
  endtask

  task automatic model_clear();
    terms = 0; r0 = 0; r8 = 0;
    ovs0 = 0; ovs8 = 0;
    es0.delete(); eo0.delete();
    es8.delete(); eo8.delete();
  endtask

  // One cycle: sample at negedge, run the multiplier model.
  task automatic step();
    @(negedge CLK);
    cyc++;
    Done = 1'b0;
    Product = 7'($urandom);
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0 && !suppress) begin
        Done = 1'b1;
        Product = mprod;
      end
    end
    if (spurious) begin
      Done = 1'b1;
      Product = 7'h15;
      spurious = 1'b0;
    end
    if (st8 === 1'b1) nst8++;
    if (st0 === 1'b1) begin
      nst0++;
      st_q.push_back(cyc);
      last_st = cyc;
      mcnt = 5;
      mprod = 7'(int'($signed(mpl0)) * int'($signed(mcd0)));
      check("mplier", mpl0, lastA);
      check("mcand", mcd0, lastB);
    end
    if (sv0 === 1'b1) begin
      nsv0++;
      check("sv0_expected", es0.size() > 0, 1'b1);
      if (es0.size() > 0) begin
        check("sum12", sum0, es0.pop_front());
        check("ovf12", ov0, eo0.pop_front());
      end
    end
    if (sv8 === 1'b1) begin
      nsv8++;
      check("sv8_expected", es8.size() > 0, 1'b1);
      if (es8.size() > 0) begin
        check("sum8", sum8, es8.pop_front());
        check("ovf8", ov8, eo8.pop_front());
      end
    end
  endtask

  task automatic send_pair(input int a, input int b);
    int n = 0;
    InValid = 1'b1;
    InA = 4'(a);
    InB = 4'(b);
    lastA = 4'(a);
    lastB = 4'(b);
    while (rdy0 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("ready_wait", rdy0, 1'b1);
    step();
    model_accept(a, b);
  endtask

  task automatic wait_sv(input int target);
    int n = 0;
    while (nsv0 < target && n < 60) begin
      step();
      n++;
    end
    check("sv_wait", nsv0, target);
  endtask

  task automatic drain_count(input string tag);
    int n = 0;
    int low = 0;
    bit stseen = 0;
    while (rdy0 !== 1'b1 && n < 30) begin
      low++;
      if (st0 === 1'b1) stseen = 1;
      step();
      n++;
    end
    check({tag, "_len"}, low, 6);
    check({tag, "_st"}, stseen, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdy"}, {rdy0, rdy8}, 2'b00);
    check({tag, "_st"}, {st0, st8}, 2'b00);
    check({tag, "_mpl"}, {mpl0, mpl8}, 8'h00);
    check({tag, "_mcd"}, {mcd0, mcd8}, 8'h00);
    check({tag, "_sum"}, {sum0, sum8}, 20'h0);
    check({tag, "_flags"}, {sv0, ov0, err0, sv8, ov8, err8}, 6'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset release with InValid held high.
    InValid = 1'b1;
    InA = 4'd3;
    InB = 4'd2;
    repeat (2) @(negedge CLK);
    check_zero("reset");
    Reset = 1'b0;
    drain_count("drain0");

    // Mixed-sign vector, streamed.
    st_q.delete();
    send_pair(3, 2);
    send_pair(-1, 5);
    send_pair(7, 7);
    send_pair(-8, 1);
    InValid = 1'b0;
    wait_sv(1);
    check("vec1_sum", sum0, 12'h02A);
    check("vec1_ovf", ov0, 1'b0);
    check("vec1_sum8", sum8, 8'h2A);
    repeat (3) step();
    check("vec1_pulses", nsv0, 1);
    check("vec1_hold", sum0, 12'h02A);
    check("vec1_st_n", st_q.size(), 4);
    for (int i = 0; i + 1 < st_q.size(); i++)
      check("vec1_st_gap", st_q[i+1] - st_q[i], 7);

    // Two back-to-back vectors.
    st_q.delete();
    for (int i = 0; i < 4; i++) send_pair(1, 1);
    for (int i = 0; i < 4; i++) send_pair(-1, 1);
    InValid = 1'b0;
    wait_sv(3);
    check("b2b_sum", sum0, 12'hFFC);
    check("b2b_sum8", sum8, 8'hFC);
    check("b2b_st_n", st_q.size(), 8);
    for (int i = 0; i + 1 < st_q.size(); i++)
      check("b2b_st_gap", st_q[i+1] - st_q[i], 7);

    // 8-bit overflow.
    for (int i = 0; i < 4; i++) send_pair(7, 7);
    InValid = 1'b0;
    wait_sv(4);
    check("ovf_sum8", sum8, 8'hC4);
    check("ovf_flag8", ov8, 1'b1);
    check("ovf_sum12", sum0, 12'h0C4);
    check("ovf_flag12", ov0, 1'b0);

    // Multiplier never answers.
    check("err_pre", err0, 1'b0);
    suppress = 1'b1;
    send_pair(2, 3);
    InValid = 1'b0;
    begin
      int n = 0;
      while (err0 !== 1'b1 && n < 40) begin
        step();
        n++;
      end
    end
    check("to_latency", cyc - last_st, 9);
    check("to_err8", err8, 1'b1);
    drain_count("drain_to");
    check("to_no_sv", nsv0, 4);
    suppress = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) send_pair(2, 3);
    InValid = 1'b0;
    wait_sv(5);
    check("to_next_sum", sum0, 12'd24);
    check("to_err_sticky", err0, 1'b1);

    // Spurious Done while idle.
    repeat (2) step();
    spurious = 1'b1;
    repeat (3) step();
    check("spur_no_sv", nsv0, 5);
    for (int i = 0; i < 4; i++) send_pair(1, 5);
    InValid = 1'b0;
    wait_sv(6);
    check("spur_sum", sum0, 12'd20);

    // Reset during WAIT of term 2.
    send_pair(1, 2);
    send_pair(1, 3);
    InValid = 1'b0;
    repeat (2) step();
    Reset = 1'b1;
    #1;
    check_zero("midrst");
    model_clear();
    repeat (2) step();
    Reset = 1'b0;
    drain_count("drain_rst");
    for (int i = 0; i < 4; i++) send_pair(1, 4);
    InValid = 1'b0;
    wait_sv(7);
    check("rst_next_sum", sum0, 12'd16);
    check("rst_err_clr", err0, 1'b0);

    repeat (3) step();
    check("sv8_total", nsv8, 7);
    check("st0_total", nst0, 31);
    check("st8_total", nst8, 31);
    check("pending12", es0.size(), 0);
    check("pending8", es8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
